// File: rtl/adc_capture_ctrl_if.sv
// rtl/adc_capture_ctrl_if.sv - FIFO write-side bus between the capture controller and the upstream FIFO
//
// Signals:
//   fifo_full   FIFO full flag (driven by the FIFO side)
//   fifo_wr_en  one-cycle write strobe (driven by the controller)
//   fifo_din    32-bit write data, held between writes (driven by the controller)
//
// Modports:
//   master  controller side: drives fifo_wr_en/fifo_din, observes fifo_full
//   slave   FIFO side: drives fifo_full, observes fifo_wr_en/fifo_din
`timescale 1ns/1ps

interface adc_capture_ctrl_if;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [31:0] fifo_din;

  modport master (
    input  fifo_full,
    output fifo_wr_en,
    output fifo_din
  );

  modport slave (
    output fifo_full,
    input  fifo_wr_en,
    input  fifo_din
  );
endinterface

// File: rtl/adc_capture_ctrl.sv
// rtl/adc_capture_ctrl.sv - capture controller packing dual-channel ADC sample pairs into 32-bit FIFO words
//
// Ports:
//   dco            capture clock (ADC data clock), the only clock
//   rst_n          asynchronous active-low reset
//   dch1, dch2     channel samples, a new pair every dco cycle
//   arm            pulse: start a capture (ignored while busy)
//   abort          pulse: return to IDLE from any state, highest priority
//   trig_mode      0 = start immediately, 1 = rising threshold crossing on channel 1
//   trig_level     unsigned channel-1 threshold, compared live
//   num_words      words to write, latched at arm
//   fifo           FIFO write bus (master side): fifo_full in, fifo_wr_en/fifo_din out
//   busy           high in ARMED and CAPTURE
//   done           high in DONE
//   overflow       sticky: a word was dropped because the FIFO was full
//   words_written  words accepted by the FIFO in the current or last capture
//
// SAMPLE_W must be in 1..7 so that each sample fits a zero-padded byte.
`timescale 1ns/1ps

module adc_capture_ctrl #(
  parameter int SAMPLE_W = 6,
  parameter int CNT_W    = 24
) (
  input  logic                dco,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] dch1,
  input  logic [SAMPLE_W-1:0] dch2,
  input  logic                arm,
  input  logic                abort,
  input  logic                trig_mode,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic [CNT_W-1:0]    num_words,
  adc_capture_ctrl_if.master  fifo,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [CNT_W-1:0]    words_written
);

  localparam int PAD = 8 - SAMPLE_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DONE
  } state_t;

  // Input stage: r1 is the newest registered pair, r2 the pair before it.
  // Only channel 1 of the previous pair is needed (for the trigger edge).
  logic [SAMPLE_W-1:0] r1_ch1, r1_ch2;
  logic [SAMPLE_W-1:0] r2_ch1;

  state_t           state_q, state_n;
  logic             half_q, half_n;
  logic [15:0]      low_q, low_n;
  logic             wr_en_q, wr_en_n;
  logic [31:0]      din_q, din_n;
  logic [CNT_W-1:0] count_q, count_n;
  logic [CNT_W-1:0] nw_q, nw_n;
  logic             ovf_q, ovf_n;

  logic [15:0]      r1_half;
  logic [CNT_W-1:0] count_inc;
  logic             trig_fire;

  always_ff @(posedge dco or negedge rst_n) begin
    if (!rst_n) begin
      r1_ch1 <= '0;
      r1_ch2 <= '0;
      r2_ch1 <= '0;
    end else begin
      r1_ch1 <= dch1;
      r1_ch2 <= dch2;
      r2_ch1 <= r1_ch1;
    end
  end

  assign r1_half   = {{PAD{1'b0}}, r1_ch2, {PAD{1'b0}}, r1_ch1};
  assign count_inc = count_q + CNT_W'(1);

  // Rising crossing: previous below, current at or above. A level of 0 can
  // never fire because nothing is below 0.
  assign trig_fire = (r2_ch1 < trig_level) && (r1_ch1 >= trig_level);

  always_ff @(posedge dco or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      half_q  <= 1'b0;
      low_q   <= '0;
      wr_en_q <= 1'b0;
      din_q   <= '0;
      count_q <= '0;
      nw_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      half_q  <= half_n;
      low_q   <= low_n;
      wr_en_q <= wr_en_n;
      din_q   <= din_n;
      count_q <= count_n;
      nw_q    <= nw_n;
      ovf_q   <= ovf_n;
    end
  end

  always_comb begin
    state_n = state_q;
    half_n  = half_q;
    low_n   = low_q;
    wr_en_n = 1'b0;
    din_n   = din_q;
    count_n = count_q;
    nw_n    = nw_q;
    ovf_n   = ovf_q;

    if (abort) begin
      // Pending half word is simply forgotten; counters and overflow stay
      // visible so the host can inspect the aborted capture.
      state_n = S_IDLE;
      half_n  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm) begin
            nw_n    = num_words;
            count_n = '0;
            ovf_n   = 1'b0;
            half_n  = 1'b0;
            state_n = (num_words == '0) ? S_DONE : S_ARMED;
          end
        end

        S_ARMED: begin
          if (!trig_mode) begin
            state_n = S_CAPTURE;
            half_n  = 1'b0;
          end else if (trig_fire) begin
            // The pair that crossed the threshold is the first captured pair.
            low_n   = r1_half;
            half_n  = 1'b1;
            state_n = S_CAPTURE;
          end
        end

        S_CAPTURE: begin
          if (!half_q) begin
            low_n  = r1_half;
            half_n = 1'b1;
          end else if (fifo.fifo_full) begin
            // Completed word cannot be accepted: drop it and stop.
            ovf_n   = 1'b1;
            half_n  = 1'b0;
            state_n = S_DONE;
          end else begin
            wr_en_n = 1'b1;
            din_n   = {r1_half, low_q};
            count_n = count_inc;
            half_n  = 1'b0;
            if (count_inc == nw_q) begin
              state_n = S_DONE;
            end
          end
        end

        default: begin
          state_n = S_IDLE;
          half_n  = 1'b0;
        end
      endcase
    end
  end

  assign fifo.fifo_wr_en = wr_en_q;
  assign fifo.fifo_din   = din_q;
  assign busy            = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign done            = (state_q == S_DONE);
  assign overflow        = ovf_q;
  assign words_written   = count_q;

endmodule
